// File: rtl/ram_dump_reader.sv
// rtl/ram_dump_reader.sv - sequential RAM word dumper with skip-zero, timeout and stream handshake
module ram_dump_reader #(
  parameter int          NWORDS    = 1024,
  parameter logic [31:0] BASE      = 32'h0,
  parameter int          TIMEOUT   = 255,
  parameter bit          SKIP_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        tbCTRL,
  output logic        REN,
  output logic        WEN,
  output logic [31:0] addr,
  output logic [31:0] store,
  input  logic [31:0] load,
  input  logic [1:0]  ramstate,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        done,
  output logic        err
);

  // Index is one bit wider than needed so the last increment can never wrap.
  localparam int            IW       = $clog2(NWORDS) + 1;
  localparam logic [IW-1:0] LAST     = IW'(NWORDS - 1);
  localparam logic [7:0]    WAIT_MAX = 8'(TIMEOUT);

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_EMIT,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] index;
  logic [7:0]    wait_cnt;
  logic          start_q;
  logic          armed;
  logic          err_q;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_data;
  logic [31:0]   req_addr;
  logic          start_edge;
  logic          access;
  logic          ram_error;

  // A start edge only counts once start has been seen low since reset, so a
  // start line held high through reset cannot launch a dump.
  assign start_edge = start && !start_q && armed;
  assign access     = (ramstate == RS_ACCESS);
  assign ram_error  = (ramstate == RS_ERROR);
  assign req_addr   = BASE + (32'(index) << 2);

  assign WEN   = 1'b0;
  assign store = 32'h0;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    state_nxt  = state;
    tbCTRL     = 1'b0;
    REN        = 1'b0;
    addr       = 32'h0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        tbCTRL = 1'b1;
        REN    = 1'b1;
        addr   = req_addr;
        if (access) begin
          if (SKIP_ZERO && (load == 32'h0)) state_nxt = ST_NEXT;
          else                              state_nxt = ST_EMIT;
        end else if (ram_error) begin
          state_nxt = ST_ERR;
        end else if (wait_cnt >= WAIT_MAX) begin
          state_nxt = ST_ERR;
        end
      end
      ST_EMIT: begin
        tbCTRL     = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        tbCTRL = 1'b1;
        if (index == LAST) state_nxt = ST_DONE;
        else               state_nxt = ST_REQ;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Start edge detector and re-arm flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      start_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
    end
  end

  // Word index: cleared on a new dump, advanced in NEXT unless on the last word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      index <= '0;
    end else if (state == ST_IDLE && start_edge) begin
      index <= '0;
    end else if (state == ST_NEXT && index != LAST) begin
      index <= index + 1'b1;
    end
  end

  // Saturating wait counter; held at zero outside REQ so every REQ entry starts fresh.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= 8'h0;
    end else if (state != ST_REQ) begin
      wait_cnt <= 8'h0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'h1;
    end
  end

  // Capture the granted word so it stays stable for the whole EMIT stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_addr <= 32'h0;
      cap_data <= 32'h0;
    end else if (state == ST_REQ && access) begin
      cap_addr <= req_addr;
      cap_data <= load;
    end
  end

  // Sticky error flag, cleared only by reset or the next accepted start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && start_edge) begin
      err_q <= 1'b0;
    end else if (state_nxt == ST_ERR) begin
      err_q <= 1'b1;
    end
  end

  assign dump_addr = cap_addr;
  assign dump_data = cap_data;
  assign err       = err_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// tb/tb_ram_dump_reader.sv - scoreboard bench for ram_dump_reader
module tb_ram_dump_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode = 2'd0;
  logic [31:0] mem [4];

  logic        start0 = 1'b0, ready0 = 1'b1;
  logic        tbctrl0, ren0, wen0, dump_valid0, done0, err0;
  logic [31:0] addr0, store0, load0, dump_addr0, dump_data0;
  logic [1:0]  ramstate0;

  logic        start1 = 1'b0, ready1 = 1'b1;
  logic        tbctrl1, ren1, wen1, dump_valid1, done1, err1;
  logic [31:0] addr1, store1, load1, dump_addr1, dump_data1;
  logic [1:0]  ramstate1;

  int tests = 0;
  int fails = 0;
  int hs0 = 0, hs1 = 0, done_cnt0 = 0, done_cnt1 = 0, valid_cnt0 = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  // RAM model: 0 always ACCESS, 1 BUSY on byte address 8, 2 always ERROR
  function automatic logic [1:0] ram_resp(input logic [1:0] m, input logic [31:0] a);
    case (m)
      2'd0:    return 2'b10;
      2'd1:    return (a == 32'h8) ? 2'b01 : 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  assign ramstate0 = ram_resp(mode, addr0);
  assign load0     = mem[addr0[3:2]];
  assign ramstate1 = ram_resp(mode, addr1);
  assign load1     = mem[addr1[3:2]];

  ram_dump_reader #(.NWORDS(4), .BASE(32'h0), .TIMEOUT(255), .SKIP_ZERO(1'b0)) u0 (
    .CLK(clk), .RST(rst), .start(start0), .tbCTRL(tbctrl0), .REN(ren0), .WEN(wen0),
    .addr(addr0), .store(store0), .load(load0), .ramstate(ramstate0),
    .dump_valid(dump_valid0), .dump_ready(ready0), .dump_addr(dump_addr0),
    .dump_data(dump_data0), .done(done0), .err(err0));

  ram_dump_reader #(.NWORDS(4), .BASE(32'h0), .TIMEOUT(255), .SKIP_ZERO(1'b1)) u1 (
    .CLK(clk), .RST(rst), .start(start1), .tbCTRL(tbctrl1), .REN(ren1), .WEN(wen1),
    .addr(addr1), .store(store1), .load(load1), .ramstate(ramstate1),
    .dump_valid(dump_valid1), .dump_ready(ready1), .dump_addr(dump_addr1),
    .dump_data(dump_data1), .done(done1), .err(err1));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop start for a cycle, raise it, and return just after the sampling edge.
  task automatic kick0();
    start0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
  endtask

  task automatic push0(input logic [31:0] a, input logic [31:0] d);
    q0.push_back({a, d});
  endtask

  // Monitor for u0: scoreboard pops on handshake, stall stability checks
  logic        stall0 = 1'b0;
  logic [31:0] st_addr0, st_data0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check("stall_valid", 32'(dump_valid0), 32'd1);
        check("stall_addr", dump_addr0, st_addr0);
        check("stall_data", dump_data0, st_data0);
        check("stall_ren", 32'(ren0), 32'd0);
      end
      if (dump_valid0 && ready0) begin
        hs0++;
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word0: got addr %0h data %0h expected no word", dump_addr0, dump_data0);
        end else begin
          e = q0.pop_front();
          check("word0_addr", dump_addr0, e[63:32]);
          check("word0_data", dump_data0, e[31:0]);
        end
      end
      if (done0) done_cnt0++;
      if (dump_valid0) valid_cnt0++;
      stall0   = dump_valid0 && !ready0;
      st_addr0 = dump_addr0;
      st_data0 = dump_data0;
    end
  end

  // Monitor for u1 (skip-zero instance)
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (dump_valid1 && ready1) begin
        hs1++;
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word1: got addr %0h data %0h expected no word", dump_addr1, dump_data1);
        end else begin
          e = q1.pop_front();
          check("word1_addr", dump_addr1, e[63:32]);
          check("word1_data", dump_data1, e[31:0]);
        end
      end
      if (done1) done_cnt1++;
    end
  end

  initial begin
    int n;
    int d_before;
    int v_before;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("reset_ctrl", 32'({tbctrl0, ren0, wen0, dump_valid0, done0, err0}), 32'd0);
    check("reset_addr", addr0, 32'h0);
    check("reset_store", store0, 32'h0);
    check("reset_dump_addr", dump_addr0, 32'h0);

    // Full dump, SKIP_ZERO=0, minimum latency
    push0(32'h0, 32'h11); push0(32'h4, 32'h22); push0(32'h8, 32'h33); push0(32'hC, 32'h44);
    kick0();
    check("a_tbctrl_rise", 32'(tbctrl0), 32'd1);
    check("a_ren", 32'(ren0), 32'd1);
    check("a_addr0", addr0, 32'h0);
    n = 0;
    while (!done0 && n < 40) begin tick(); n++; end
    check("a_done_seen", 32'(done0), 32'd1);
    check("a_done_latency", 32'(n), 32'd12);
    tick();
    check("a_tbctrl_after", 32'(tbctrl0), 32'd0);
    check("a_done_pulse", 32'(done0), 32'd0);
    check("a_queue_empty", 32'(q0.size()), 32'd0);
    check("a_done_count", 32'(done_cnt0), 32'd1);
    check("a_handshakes", 32'(hs0), 32'd4);

    // SKIP_ZERO=1 with words {5,0,0,7}
    mem[0] = 32'h5; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h7;
    q1.push_back({32'h0, 32'h5});
    q1.push_back({32'hC, 32'h7});
    start1 = 1'b1;
    tick();
    n = 0;
    while (!done1 && n < 40) begin tick(); n++; end
    check("b_done_seen", 32'(done1), 32'd1);
    check("b_done_latency", 32'(n), 32'd10);
    tick();
    check("b_handshakes", 32'(hs1), 32'd2);
    check("b_queue_empty", 32'(q1.size()), 32'd0);
    check("b_done_count", 32'(done_cnt1), 32'd1);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    // Consumer stall of 10 cycles on word 1
    push0(32'h0, 32'h11); push0(32'h4, 32'h22); push0(32'h8, 32'h33); push0(32'hC, 32'h44);
    kick0();
    n = 0;
    while (!(dump_valid0 && dump_addr0 == 32'h4) && n < 20) begin tick(); n++; end
    check("c_emit1_seen", 32'(dump_valid0 && dump_addr0 == 32'h4), 32'd1);
    ready0 = 1'b0;
    repeat (10) tick();
    check("c_hold_valid", 32'(dump_valid0), 32'd1);
    check("c_hold_data", dump_data0, 32'h22);
    check("c_hold_ren", 32'(ren0), 32'd0);
    ready0 = 1'b1;
    n = 0;
    while (!done0 && n < 40) begin tick(); n++; end
    check("c_done_seen", 32'(done0), 32'd1);
    tick();
    check("c_queue_empty", 32'(q0.size()), 32'd0);

    // BUSY forever on word 2 -> timeout error, then clean restart
    d_before = done_cnt0;
    mode = 2'd1;
    push0(32'h0, 32'h11); push0(32'h4, 32'h22);
    kick0();
    n = 0;
    while (!err0 && n < 400) begin tick(); n++; end
    check("d_err_seen", 32'(err0), 32'd1);
    check("d_err_latency", 32'(n), 32'd262);
    check("d_tbctrl_err", 32'(tbctrl0), 32'd0);
    repeat (3) tick();
    check("d_err_sticky", 32'(err0), 32'd1);
    check("d_no_done", 32'(done_cnt0), 32'(d_before));
    check("d_queue_empty", 32'(q0.size()), 32'd0);
    mode = 2'd0;
    push0(32'h0, 32'h11); push0(32'h4, 32'h22); push0(32'h8, 32'h33); push0(32'hC, 32'h44);
    kick0();
    check("d_err_cleared", 32'(err0), 32'd0);
    check("d_restart_addr", addr0, 32'h0);
    check("d_restart_ren", 32'(ren0), 32'd1);
    n = 0;
    while (!done0 && n < 40) begin tick(); n++; end
    check("d_restart_latency", 32'(n), 32'd12);
    tick();
    check("d_restart_queue", 32'(q0.size()), 32'd0);

    // Reset mid-dump during EMIT of word 2, start held high
    push0(32'h0, 32'h11); push0(32'h4, 32'h22);
    kick0();
    n = 0;
    while (!(dump_valid0 && dump_addr0 == 32'h8) && n < 20) begin tick(); n++; end
    check("e_emit2_seen", 32'(dump_valid0 && dump_addr0 == 32'h8), 32'd1);
    ready0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("e_rst_ctrl", 32'({tbctrl0, ren0, wen0, dump_valid0, done0, err0}), 32'd0);
    check("e_rst_addr", addr0, 32'h0);
    check("e_rst_dump_addr", dump_addr0, 32'h0);
    check("e_rst_dump_data", dump_data0, 32'h0);
    ready0 = 1'b1;
    repeat (6) tick();
    check("e_no_restart", 32'({tbctrl0, ren0}), 32'd0);
    check("e_queue_empty", 32'(q0.size()), 32'd0);

    // ERROR on word 0
    mode = 2'd2;
    v_before = valid_cnt0;
    d_before = done_cnt0;
    kick0();
    n = 0;
    while (!err0 && n < 20) begin tick(); n++; end
    check("f_err_seen", 32'(err0), 32'd1);
    check("f_err_latency", 32'(n), 32'd1);
    repeat (4) tick();
    check("f_no_valid", 32'(valid_cnt0), 32'(v_before));
    check("f_no_done", 32'(done_cnt0), 32'(d_before));
    check("f_tbctrl", 32'(tbctrl0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_dump_reader.md
RAM_DUMP_READER -- requirements
Module: ram_dump_reader

Parameters
REQ-001 The block SHALL have parameter NWORDS, default 1024: number of 32-bit words read per dump.
REQ-002 The block SHALL have parameter BASE, default 32'h0: byte address of the first word read; must be word-aligned.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: maximum wait in cycles for ACCESS on one request.
REQ-004 The block SHALL have parameter SKIP_ZERO, default 1: when 1, zero-valued words are not emitted.

Interface
REQ-005 Ports SHALL be: CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; a 0->1 transition sampled in IDLE begins a dump (intended to connect to CPU halt).
REQ-008 tbCTRL  out  1  high while the block owns the RAM port.
REQ-009 REN  out  1  RAM read request.
REQ-010 WEN  out  1  RAM write request; SHALL be constant 0.
REQ-011 addr  out  32  RAM byte address.
REQ-012 store  out  32  RAM write data; SHALL be constant 0.
REQ-013 load  in  32  RAM read data; valid when ramstate=ACCESS.
REQ-014 ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
REQ-015 dump_valid  out  1  dump_addr/dump_data hold a word for the consumer.
REQ-016 dump_ready  in  1  consumer accepts the word.
REQ-017 dump_addr  out  32  byte address of the emitted word.
REQ-018 dump_data  out  32  emitted word.
REQ-019 done  out  1  one-cycle pulse when a dump completes without error.
REQ-020 err  out  1  sticky error flag; cleared only by RST or by the next start edge.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ, EMIT, NEXT, DONE and ERR.
REQ-022 IDLE: on a start rising edge, set the index to 0, clear err and go to REQ; tbCTRL SHALL rise in the same cycle the state becomes REQ.
REQ-023 REQ: assert REN=1, addr=BASE+4*index, tbCTRL=1.
- On ramstate=ACCESS, capture load and addr, drop REN in the next cycle, and go to EMIT.
- If SKIP_ZERO=1 and load==0, go to NEXT instead of EMIT.
REQ-024 REQ: ramstate=ERROR, or a wait counter reaching TIMEOUT with no ACCESS, SHALL go to ERR.
- The wait counter is 8 bits, reset on entry to REQ, and saturating.
REQ-025 EMIT: hold dump_valid=1 with stable dump_addr/dump_data until the cycle dump_valid&&dump_ready, then go to NEXT.
- tbCTRL stays 1 in EMIT.
- REN=0 in EMIT.
REQ-026 NEXT: if index==NWORDS-1, go to DONE; otherwise increment index and go to REQ.
- NEXT takes exactly one cycle.
- The index is $clog2(NWORDS)+1 bits so it never wraps.
REQ-027 DONE: pulse done=1 for one cycle, drop tbCTRL, return to IDLE.
REQ-028 ERR: set err=1, REN=0, tbCTRL=0, dump_valid=0, return to IDLE next cycle.
REQ-029 Minimum latency per non-skipped word SHALL be 3 cycles (REQ with immediate ACCESS, EMIT with ready=1, NEXT).
REQ-030 Edge detection SHALL use a registered copy of start; start held high SHALL NOT retrigger after DONE until it falls and rises again.
REQ-031 A start edge while not in IDLE SHALL be ignored.
REQ-032 dump_ready while dump_valid=0 SHALL have no effect.
REQ-033 ramstate ACCESS while REN=0 SHALL be ignored.

Reset
REQ-034 RST=1 at any clock edge SHALL force IDLE, index=0, wait counter=0, start-edge register=0, and all outputs to 0, including mid-dump.
REQ-035 After reset, the block SHALL NOT start until a fresh 0->1 on start.

Verification
REQ-036 Bench SHALL drive NWORDS=4, BASE=0, SKIP_ZERO=0, RAM always ACCESS, ready=1, and start 0->1.
- tbCTRL rises next cycle.
- Emits addr 0,4,8,C with RAM data in order.
- done pulses once 12 cycles after start sampled; tbCTRL=0 after.
REQ-037 Bench SHALL repeat with SKIP_ZERO=1 and RAM words {5,0,0,7}.
- Exactly two handshakes: (0,5) then (C,7).
- done pulses.
REQ-038 Bench SHALL hold dump_ready=0 for 10 cycles during EMIT of word 1.
- dump_valid/addr/data stay stable.
- REN stays 0.
- Progress resumes on ready=1.
REQ-039 Bench SHALL hold ramstate=BUSY forever on word 2.
- err=1 after 255 wait cycles; tbCTRL=0; no done.
- A new start edge clears err and restarts at BASE.
REQ-040 Bench SHALL assert RST for one cycle during EMIT of word 2.
- All outputs are 0 next cycle.
- start held high does not restart the dump.
REQ-041 Bench SHALL return ramstate=ERROR on word 0.
- err=1 and no dump_valid ever asserts.
